// File: rtl/wd_pkg.sv
// Shared definitions for the windowed-watchdog supervisor: FSM state
// encodings, default parameter values and the fault-counter width helper.
package wd_pkg;

    // Default parameter values for wd_window_ctrl
    localparam int CW_W_DEF        = 16;
    localparam int FAULT_LIMIT_DEF = 3;
    localparam int RSTOUT_LEN_DEF  = 8;

    // Supervisor FSM states; the encoding is visible on the STATE output
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLOSED = 2'd1,
        ST_OPEN   = 2'd2,
        ST_ESCAL  = 2'd3
    } wd_state_e;

    // Bits needed to hold a fault count from 0 up to and including limit
    function automatic int fcnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wd_pulse_stretch.sv
// Loadable down-counter that turns a one-cycle start strobe into a
// registered pulse exactly LEN cycles long. done_o marks the final cycle.
module wd_pulse_stretch #(
    parameter int LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic busy_o,
    output logic done_o
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load LEN-1 on start, then count down while the pulse is active
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = CNT_W'(LEN - 1);
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Pulse flag is reset; the count is only meaningful while active
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
        end else begin
            active_q <= active_d;
        end
        cnt_q <= cnt_d;
    end

    assign busy_o = active_q;
    assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/wd_window_ctrl.sv
// Windowed-watchdog supervisor. Enforces a closed (too-early) window after
// each restart, classifies services as valid, early or late, keeps a fault
// count with one-step forgiveness per valid service, and escalates to a
// stretched system reset when the fault limit is reached.
module wd_window_ctrl
    import wd_pkg::*;
#(
    parameter int CW_W        = CW_W_DEF,
    parameter int FAULT_LIMIT = FAULT_LIMIT_DEF,
    parameter int RSTOUT_LEN  = RSTOUT_LEN_DEF
) (
    input  logic                               CLK,
    input  logic                               WDRST,
    input  logic                               EN,
    input  logic                               WDSRVC,
    input  logic                               FWOVR,
    input  logic [CW_W-1:0]                    CWLEN,
    output logic                               SRVC_ACK,
    output logic                               EARLY_ERR,
    output logic                               LATE_ERR,
    output logic                               FWRST,
    output logic [fcnt_width(FAULT_LIMIT)-1:0] FAULT_CNT,
    output logic                               SYSRST,
    output logic [1:0]                         STATE
);

    localparam int              FC_W   = fcnt_width(FAULT_LIMIT);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(FAULT_LIMIT);

    wd_state_e       state_q, state_d;
    logic [FC_W-1:0] fault_q, fault_d;
    logic [FC_W-1:0] fault_inc, fault_dec;
    logic            prev_q, prev_d;
    logic            ack_q, ack_d;
    logic            early_q, early_d;
    logic            late_q, late_d;
    logic            fwrst_q, fwrst_d;
    logic            start_q, start_d;
    logic [CW_W-1:0] win_cnt_q, win_cnt_d;
    logic [CW_W-1:0] cwlen_q, cwlen_d;
    logic            load_win;
    logic            win_done;
    logic            fwovr_rise;
    logic            stretch_done;
    wd_state_e       entry_st;

    // A zero-length closed window restarts straight into OPEN
    assign entry_st   = (CWLEN == '0) ? ST_OPEN : ST_CLOSED;
    assign fwovr_rise = FWOVR && !prev_q;
    assign win_done   = (win_cnt_q == cwlen_q - CW_W'(1));
    assign fault_inc  = (fault_q >= FC_MAX) ? FC_MAX : fault_q + FC_W'(1);
    assign fault_dec  = (fault_q == '0) ? '0 : fault_q - FC_W'(1);

    // Next-state, fault-count and pulse decisions; a late fault outranks a service
    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        prev_d   = 1'b0;
        ack_d    = 1'b0;
        early_d  = 1'b0;
        late_d   = 1'b0;
        fwrst_d  = 1'b0;
        load_win = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (EN) begin
                    fwrst_d  = 1'b1;
                    state_d  = entry_st;
                    load_win = 1'b1;
                end
            end
            ST_CLOSED, ST_OPEN: begin
                prev_d = FWOVR;
                if (!EN) begin
                    state_d = ST_IDLE;
                end else if (fwovr_rise || (WDSRVC && state_q == ST_CLOSED)) begin
                    late_d  = fwovr_rise;
                    early_d = !fwovr_rise;
                    fwrst_d = 1'b1;
                    fault_d = fault_inc;
                    if (fault_inc == FC_MAX) begin
                        state_d = ST_ESCAL;
                    end else begin
                        state_d  = entry_st;
                        load_win = 1'b1;
                    end
                end else if (WDSRVC) begin
                    ack_d    = 1'b1;
                    fwrst_d  = 1'b1;
                    fault_d  = fault_dec;
                    state_d  = entry_st;
                    load_win = 1'b1;
                end else if (state_q == ST_CLOSED && win_done) begin
                    state_d = ST_OPEN;
                end
            end
            ST_ESCAL: begin
                fault_d = '0;
                if (stretch_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign start_d   = (state_d == ST_ESCAL) && (state_q != ST_ESCAL);
    assign win_cnt_d = load_win ? '0 :
                       (state_q == ST_CLOSED) ? win_cnt_q + CW_W'(1) : win_cnt_q;
    assign cwlen_d   = load_win ? CWLEN : cwlen_q;

    // Control state and registered output pulses
    always_ff @(posedge CLK) begin
        if (WDRST) begin
            state_q <= ST_IDLE;
            fault_q <= '0;
            prev_q  <= 1'b0;
            ack_q   <= 1'b0;
            early_q <= 1'b0;
            late_q  <= 1'b0;
            fwrst_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            prev_q  <= prev_d;
            ack_q   <= ack_d;
            early_q <= early_d;
            late_q  <= late_d;
            fwrst_q <= fwrst_d;
            start_q <= start_d;
        end
    end

    // Closed-window counter and the window length captured on entry
    always_ff @(posedge CLK) begin
        win_cnt_q <= win_cnt_d;
        cwlen_q   <= cwlen_d;
    end

    wd_pulse_stretch #(
        .LEN (RSTOUT_LEN)
    ) u_sysrst (
        .clk_i   (CLK),
        .rst_i   (WDRST),
        .start_i (start_q),
        .busy_o  (SYSRST),
        .done_o  (stretch_done)
    );

    assign SRVC_ACK  = ack_q;
    assign EARLY_ERR = early_q;
    assign LATE_ERR  = late_q;
    assign FWRST     = fwrst_q;
    assign FAULT_CNT = fault_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_wd_window_ctrl.sv
// Bench for wd_window_ctrl: directed scenarios plus a randomized run, all
// compared cycle by cycle against a time-based behavioural model.
module tb_wd_window_ctrl;

    localparam int CW_W        = 16;
    localparam int FAULT_LIMIT = 3;
    localparam int RSTOUT_LEN  = 8;

    logic            CLK = 1'b0;
    logic            WDRST, EN, WDSRVC, FWOVR;
    logic [CW_W-1:0] CWLEN;
    logic            SRVC_ACK, EARLY_ERR, LATE_ERR, FWRST, SYSRST;
    logic [1:0]      FAULT_CNT, STATE;

    int vecs = 0;
    int errs = 0;

    wd_window_ctrl #(
        .CW_W        (CW_W),
        .FAULT_LIMIT (FAULT_LIMIT),
        .RSTOUT_LEN  (RSTOUT_LEN)
    ) dut (
        .CLK       (CLK),
        .WDRST     (WDRST),
        .EN        (EN),
        .WDSRVC    (WDSRVC),
        .FWOVR     (FWOVR),
        .CWLEN     (CWLEN),
        .SRVC_ACK  (SRVC_ACK),
        .EARLY_ERR (EARLY_ERR),
        .LATE_ERR  (LATE_ERR),
        .FWRST     (FWRST),
        .FAULT_CNT (FAULT_CNT),
        .SYSRST    (SYSRST),
        .STATE     (STATE)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: mode 0 = idle, 1 = supervising, 2 = escalating.
    // The closed window is tracked as the absolute cycle at which it opens.
    int  cyc       = 0;
    int  m_mode    = 0;
    int  m_open_at = 0;
    int  m_esc_at  = 0;
    int  m_fault   = 0;
    bit  m_prev    = 1'b0;
    bit  e_ack = 1'b0, e_early = 1'b0, e_late = 1'b0, e_fwrst = 1'b0;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        srv;
        logic        fov;
        logic [15:0] cw;
    } stim_t;

    stim_t sq[$];

    function automatic logic [8:0] dut_vec();
        return {STATE, FAULT_CNT, SYSRST, SRVC_ACK, EARLY_ERR, LATE_ERR, FWRST};
    endfunction

    function automatic logic [8:0] mdl_vec();
        logic [1:0] st;
        logic [1:0] fc;
        logic       sr;
        case (m_mode)
            0:       st = 2'd0;
            1:       st = (cyc < m_open_at) ? 2'd1 : 2'd2;
            default: st = 2'd3;
        endcase
        fc = 2'(m_fault);
        sr = (m_mode == 2) && (cyc > m_esc_at) && (cyc <= m_esc_at + RSTOUT_LEN);
        return {st, fc, sr, e_ack, e_early, e_late, e_fwrst};
    endfunction

    task automatic model_enter(input int c);
        m_mode    = 1;
        m_open_at = c + 1 + int'(CWLEN);
    endtask

    task automatic model_fault(input int c);
        e_fwrst = 1'b1;
        m_fault = m_fault + 1;
        if (m_fault >= FAULT_LIMIT) begin
            m_fault  = FAULT_LIMIT;
            m_mode   = 2;
            m_esc_at = c + 1;
            m_prev   = 1'b0;
        end else begin
            model_enter(c);
        end
    endtask

    task automatic model_step();
        int c;
        bit rise;
        c       = cyc;
        e_ack   = 1'b0;
        e_early = 1'b0;
        e_late  = 1'b0;
        e_fwrst = 1'b0;
        if (WDRST) begin
            m_mode  = 0;
            m_fault = 0;
            m_prev  = 1'b0;
        end else if (m_mode == 0) begin
            if (EN) begin
                e_fwrst = 1'b1;
                model_enter(c);
            end
        end else if (m_mode == 1) begin
            rise   = FWOVR && !m_prev;
            m_prev = FWOVR;
            if (!EN) begin
                m_mode = 0;
                m_prev = 1'b0;
            end else if (rise) begin
                e_late = 1'b1;
                model_fault(c);
            end else if (WDSRVC && c < m_open_at) begin
                e_early = 1'b1;
                model_fault(c);
            end else if (WDSRVC) begin
                e_ack   = 1'b1;
                e_fwrst = 1'b1;
                if (m_fault > 0) m_fault = m_fault - 1;
                model_enter(c);
            end
        end
        cyc = c + 1;
        if (m_mode == 2 && cyc > m_esc_at) m_fault = 0;
        if (m_mode == 2 && cyc > m_esc_at + RSTOUT_LEN) begin
            m_mode = 0;
            m_prev = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic drive_s(input stim_t s);
        WDRST  = s.rst;
        EN     = s.en;
        WDSRVC = s.srv;
        FWOVR  = s.fov;
        CWLEN  = CW_W'(s.cw);
    endtask

    task automatic push(input bit r, input bit e, input bit s, input bit f, input int cw, input int n);
        stim_t t;
        t.rst = r;
        t.en  = e;
        t.srv = s;
        t.fov = f;
        t.cw  = 16'(cw);
        for (int k = 0; k < n; k++) sq.push_back(t);
    endtask

    task automatic apply_reset();
        WDRST = 1'b1; EN = 1'b0; WDSRVC = 1'b0; FWOVR = 1'b0; CWLEN = '0;
        tick();
        tick();
        WDRST = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            WDRST  = 1'b1;
            EN     = 1'(i != 0);
            WDSRVC = 1'($urandom_range(0, 1));
            FWOVR  = 1'($urandom_range(0, 1));
            CWLEN  = CW_W'($urandom_range(0, 7));
            tick();
            vecs++;
            if (dut_vec() !== 9'd0) begin
                errs++;
                $display("FAIL reset step %0d: got %b, want %b", i, dut_vec(), 9'd0);
            end
        end
        WDRST = 1'b0; EN = 1'b0; WDSRVC = 1'b1; FWOVR = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vecs++;
            if (dut_vec() !== 9'd0) begin
                errs++;
                $display("FAIL idle_hold step %0d: got %b, want %b", i, dut_vec(), 9'd0);
            end
        end
    endtask

    task automatic test_valid_service();
        apply_reset();
        sq.delete();
        push(0, 1, 0, 0, 4, 7);
        push(0, 1, 1, 0, 4, 1);
        push(0, 1, 0, 0, 4, 6);
        for (int i = 0; i < sq.size(); i++) begin
            drive_s(sq[i]);
            tick();
            vecs++;
            if (dut_vec() !== mdl_vec()) begin
                errs++;
                $display("FAIL valid_svc step %0d: dut %b model %b", i, dut_vec(), mdl_vec());
            end
            if (i == 3 || i == 4) begin
                vecs++;
                if (STATE !== ((i == 3) ? 2'd1 : 2'd2)) begin
                    errs++;
                    $display("FAIL valid_svc_open step %0d: STATE %0d", i, STATE);
                end
            end
            if (i == 7) begin
                vecs++;
                if ({SRVC_ACK, FWRST, EARLY_ERR, STATE, FAULT_CNT} !== 7'b1100100) begin
                    errs++;
                    $display("FAIL valid_svc_ack: ack/fwrst/early/state/fcnt %b want 1100100",
                             {SRVC_ACK, FWRST, EARLY_ERR, STATE, FAULT_CNT});
                end
            end
        end
    endtask

    task automatic test_early_service();
        apply_reset();
        sq.delete();
        push(0, 1, 0, 0, 10, 4);
        push(0, 1, 1, 0, 10, 1);
        push(0, 1, 0, 0, 10, 12);
        for (int i = 0; i < sq.size(); i++) begin
            drive_s(sq[i]);
            tick();
            vecs++;
            if (dut_vec() !== mdl_vec()) begin
                errs++;
                $display("FAIL early_svc step %0d: dut %b model %b", i, dut_vec(), mdl_vec());
            end
            if (i == 4) begin
                vecs++;
                if ({EARLY_ERR, FWRST, SRVC_ACK, FAULT_CNT, STATE} !== 7'b1100101) begin
                    errs++;
                    $display("FAIL early_svc_pulse: early/fwrst/ack/fcnt/state %b want 1100101",
                             {EARLY_ERR, FWRST, SRVC_ACK, FAULT_CNT, STATE});
                end
            end
            if (i == 13 || i == 14) begin
                vecs++;
                if (STATE !== ((i == 13) ? 2'd1 : 2'd2)) begin
                    errs++;
                    $display("FAIL early_restart step %0d: STATE %0d", i, STATE);
                end
            end
        end
    endtask

    task automatic test_late_collision();
        apply_reset();
        sq.delete();
        push(0, 1, 0, 0, 2, 4);
        push(0, 1, 1, 1, 2, 1);
        push(0, 1, 0, 1, 2, 3);
        push(0, 1, 0, 0, 2, 4);
        for (int i = 0; i < sq.size(); i++) begin
            drive_s(sq[i]);
            tick();
            vecs++;
            if (dut_vec() !== mdl_vec()) begin
                errs++;
                $display("FAIL late_coll step %0d: dut %b model %b", i, dut_vec(), mdl_vec());
            end
            if (i == 4) begin
                vecs++;
                if ({LATE_ERR, SRVC_ACK, EARLY_ERR, FWRST, FAULT_CNT} !== 6'b100101) begin
                    errs++;
                    $display("FAIL late_coll_pulse: late/ack/early/fwrst/fcnt %b want 100101",
                             {LATE_ERR, SRVC_ACK, EARLY_ERR, FWRST, FAULT_CNT});
                end
            end
            if (i == 6) begin
                vecs++;
                if (LATE_ERR !== 1'b0 || FAULT_CNT !== 2'd1) begin
                    errs++;
                    $display("FAIL late_sticky: LATE_ERR %b FAULT_CNT %0d, want 0 and 1", LATE_ERR, FAULT_CNT);
                end
            end
        end
    endtask

    task automatic test_sticky_fwovr();
        sq.delete();
        push(1, 0, 0, 1, 5, 2);
        push(0, 0, 1, 1, 5, 3);
        push(0, 1, 0, 1, 5, 2);
        push(0, 1, 0, 0, 5, 4);
        for (int i = 0; i < sq.size(); i++) begin
            drive_s(sq[i]);
            tick();
            vecs++;
            if (dut_vec() !== mdl_vec()) begin
                errs++;
                $display("FAIL sticky_fwovr step %0d: dut %b model %b", i, dut_vec(), mdl_vec());
            end
            if (i == 4) begin
                vecs++;
                if (dut_vec() !== 9'd0) begin
                    errs++;
                    $display("FAIL idle_ignore: got %b, want %b", dut_vec(), 9'd0);
                end
            end
            if (i == 6) begin
                vecs++;
                if (LATE_ERR !== 1'b1 || FAULT_CNT !== 2'd1) begin
                    errs++;
                    $display("FAIL sticky_late: LATE_ERR %b FAULT_CNT %0d, want 1 and 1", LATE_ERR, FAULT_CNT);
                end
            end
        end
    endtask

    task automatic test_escalation();
        int hi;
        hi = 0;
        apply_reset();
        sq.delete();
        push(0, 1, 0, 0, 10, 1);
        push(0, 1, 1, 0, 10, 1);
        push(0, 1, 0, 0, 10, 1);
        push(0, 1, 1, 0, 10, 1);
        push(0, 1, 0, 0, 10, 1);
        push(0, 1, 1, 0, 10, 1);
        push(0, 0, 1, 1, 10, 12);
        for (int i = 0; i < sq.size(); i++) begin
            drive_s(sq[i]);
            tick();
            vecs++;
            if (dut_vec() !== mdl_vec()) begin
                errs++;
                $display("FAIL escal step %0d: dut %b model %b", i, dut_vec(), mdl_vec());
            end
            if (SYSRST === 1'b1) hi++;
            if (i == 5) begin
                vecs++;
                if ({EARLY_ERR, STATE, FAULT_CNT, SYSRST} !== 6'b111110) begin
                    errs++;
                    $display("FAIL escal_entry: early/state/fcnt/sysrst %b want 111110",
                             {EARLY_ERR, STATE, FAULT_CNT, SYSRST});
                end
            end
            if (i == 6) begin
                vecs++;
                if (SYSRST !== 1'b1 || FAULT_CNT !== 2'd0) begin
                    errs++;
                    $display("FAIL escal_rise: SYSRST %b FAULT_CNT %0d, want 1 and 0", SYSRST, FAULT_CNT);
                end
            end
        end
        vecs++;
        if (hi != RSTOUT_LEN || STATE !== 2'd0 || FAULT_CNT !== 2'd0) begin
            errs++;
            $display("FAIL escal_len: SYSRST cycles %0d STATE %0d FAULT_CNT %0d, want %0d, 0, 0",
                     hi, STATE, FAULT_CNT, RSTOUT_LEN);
        end
    endtask

    task automatic test_forgive_reset();
        apply_reset();
        sq.delete();
        push(0, 1, 0, 0, 3, 1);
        push(0, 1, 1, 0, 3, 1);
        push(0, 1, 0, 0, 3, 1);
        push(0, 1, 1, 0, 3, 1);
        push(0, 1, 0, 0, 3, 3);
        push(0, 1, 1, 0, 3, 2);
        push(0, 1, 0, 0, 3, 1);
        push(0, 1, 1, 0, 3, 1);
        push(0, 1, 0, 0, 3, 3);
        push(1, 1, 0, 0, 3, 1);
        push(0, 1, 0, 0, 3, 3);
        for (int i = 0; i < sq.size(); i++) begin
            drive_s(sq[i]);
            tick();
            vecs++;
            if (dut_vec() !== mdl_vec()) begin
                errs++;
                $display("FAIL forgive step %0d: dut %b model %b", i, dut_vec(), mdl_vec());
            end
            if (i == 7) begin
                vecs++;
                if (SRVC_ACK !== 1'b1 || FAULT_CNT !== 2'd1) begin
                    errs++;
                    $display("FAIL forgive_dec: SRVC_ACK %b FAULT_CNT %0d, want 1 and 1", SRVC_ACK, FAULT_CNT);
                end
            end
            if (i == 13) begin
                vecs++;
                if (SYSRST !== 1'b1) begin
                    errs++;
                    $display("FAIL escal_cycle3: SYSRST %b, want 1", SYSRST);
                end
            end
            if (i == 14) begin
                vecs++;
                if (SYSRST !== 1'b0 || STATE !== 2'd0 || FAULT_CNT !== 2'd0) begin
                    errs++;
                    $display("FAIL escal_reset: SYSRST %b STATE %0d FAULT_CNT %0d, want 0 0 0",
                             SYSRST, STATE, FAULT_CNT);
                end
            end
        end
    endtask

    task automatic test_cwlen_zero();
        apply_reset();
        sq.delete();
        push(0, 1, 0, 0, 0, 1);
        push(0, 1, 1, 0, 0, 1);
        push(0, 1, 0, 0, 0, 2);
        push(0, 1, 1, 0, 0, 3);
        push(0, 1, 0, 0, 0, 2);
        for (int i = 0; i < sq.size(); i++) begin
            drive_s(sq[i]);
            tick();
            vecs++;
            if (dut_vec() !== mdl_vec()) begin
                errs++;
                $display("FAIL cwlen0 step %0d: dut %b model %b", i, dut_vec(), mdl_vec());
            end
            if (i == 0) begin
                vecs++;
                if (STATE !== 2'd2 || FWRST !== 1'b1) begin
                    errs++;
                    $display("FAIL cwlen0_open: STATE %0d FWRST %b, want 2 and 1", STATE, FWRST);
                end
            end
            if (i == 1 || i == 5) begin
                vecs++;
                if ({SRVC_ACK, EARLY_ERR, STATE} !== 4'b1010) begin
                    errs++;
                    $display("FAIL cwlen0_ack step %0d: ack/early/state %b want 1010",
                             i, {SRVC_ACK, EARLY_ERR, STATE});
                end
            end
        end
    endtask

    task automatic test_random();
        bit en_r, fov_r;
        en_r  = 1'b1;
        fov_r = 1'b0;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) en_r = ~en_r;
            if (e_fwrst) fov_r = 1'b0;
            else if ($urandom_range(0, 24) == 0) fov_r = 1'b1;
            WDRST  = ($urandom_range(0, 299) == 0);
            EN     = en_r;
            WDSRVC = ($urandom_range(0, 5) == 0);
            FWOVR  = fov_r;
            CWLEN  = CW_W'($urandom_range(0, 6));
            tick();
            vecs++;
            if (dut_vec() !== mdl_vec()) begin
                errs++;
                $display("FAIL random cyc %0d: dut %b model %b", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        WDRST = 1'b1; EN = 1'b0; WDSRVC = 1'b0; FWOVR = 1'b0; CWLEN = '0;
        test_reset();
        test_valid_service();
        test_early_service();
        test_late_collision();
        test_sticky_fwovr();
        test_escalation();
        test_forgive_reset();
        test_cwlen_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/wd_window_ctrl.md
# wd_window_ctrl

Windowed-watchdog supervisor sitting directly downstream of the frame-window counter. It consumes the frame-overflow flag (FWOVR) and the raw service strobe, enforces a closed (too-early) window before each service, and classifies every service as valid, early or late. It also counts faults with partial forgiveness, drives a frame-window restart pulse, and escalates to a stretched system-reset output once the fault limit is reached.

## Interface
Parameters:
- CW_W, 16: width of closed-window length and counter.
- FAULT_LIMIT, 3: fault count that triggers escalation (≥1).
- RSTOUT_LEN, 8: SYSRST pulse length in cycles (≥1).

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- WDRST  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- EN  in  1  supervisor enable.
- WDSRVC  in  1  service strobe, one cycle per service.
- FWOVR  in  1  frame-overflow flag from the frame-window stage, sticky until that stage is reset.
- CWLEN  in  CW_W  closed-window length in cycles; sampled on entry to CLOSED.
- SRVC_ACK  out  1  one-cycle pulse for an accepted service.
- EARLY_ERR  out  1  one-cycle pulse for a service inside the closed window.
- LATE_ERR  out  1  one-cycle pulse for a frame overflow without a service.
- FWRST  out  1  one-cycle restart pulse to the frame-window stage's WDRST input.
- FAULT_CNT  out  clog2(FAULT_LIMIT+1)  current fault count.
- SYSRST  out  1  escalation reset, high for exactly RSTOUT_LEN cycles.
- STATE  out  2  current FSM state.

## Operation
- FSM states: IDLE=0, CLOSED=1, OPEN=2, ESCAL=3.
- IDLE: WDSRVC and FWOVR are ignored. When EN=1, go to CLOSED and pulse FWRST.
- CLOSED: a counter loads 0 on entry and increments each cycle. When the count equals CWLEN-1, go to OPEN. CWLEN=0 skips CLOSED and enters OPEN directly.
- A WDSRVC seen in CLOSED is an early fault:
  - EARLY_ERR pulses.
  - FAULT_CNT increments.
  - FWRST pulses.
  - CLOSED restarts from 0.
- OPEN, WDSRVC=1 with no FWOVR rising edge is a valid service:
  - SRVC_ACK pulses.
  - FAULT_CNT decrements, saturating at 0.
  - FWRST pulses.
  - Go to CLOSED.
- OPEN, FWOVR rising edge (current FWOVR=1, registered previous=0) is a late fault:
  - LATE_ERR pulses.
  - FAULT_CNT increments.
  - FWRST pulses.
  - Go to CLOSED.
- Same-cycle WDSRVC and FWOVR rising edge: the late fault wins, and SRVC_ACK is not asserted.
- A FWOVR rising edge in CLOSED is also a late fault, handled the same way.
- Any fault that brings FAULT_CNT to FAULT_LIMIT goes to ESCAL instead of CLOSED.
- ESCAL:
  - SYSRST is high for RSTOUT_LEN cycles.
  - FAULT_CNT clears to 0 on entry.
  - WDSRVC and FWOVR are ignored.
  - After RSTOUT_LEN cycles, go to IDLE.
- EN=0 in CLOSED or OPEN: go to IDLE next cycle; FAULT_CNT is held.
- EN=0 does not abort ESCAL; the pulse always completes.
- FAULT_CNT never exceeds FAULT_LIMIT.

## Timing
- All outputs are registered.
- Reset values (WDRST=1): STATE=IDLE, FAULT_CNT=0, SYSRST=0, and all pulses are 0.
- WDRST has priority over every other input. Reset asserted mid-ESCAL drops SYSRST in the next cycle.
- Pulse latency: SRVC_ACK, EARLY_ERR, LATE_ERR and FWRST assert in the cycle after the triggering input is sampled, and last exactly one cycle.
- SYSRST rises in the cycle after the escalating fault pulse and stays high for RSTOUT_LEN consecutive cycles.
- With CWLEN=N, STATE=OPEN appears N cycles after STATE=CLOSED first appears.
- The FWOVR edge register resets to 0. A FWOVR that is already high out of reset therefore counts as a rising edge once EN is set and the FSM leaves IDLE.

## Structure
- Package wd_pkg holds:
  - state encodings (IDLE, CLOSED, OPEN, ESCAL);
  - default parameter constants (CW_W, FAULT_LIMIT, RSTOUT_LEN);
  - the fault-count width function.
- One sub-module, wd_pulse_stretch: loadable down-counter producing SYSRST, with a start input, a busy/done output, and parameter LEN.
- The FSM, window counter, edge detector and fault counter live in wd_window_ctrl.

## Test plan
- Valid service: CWLEN=4, EN=1, WDSRVC 6 cycles after CLOSED entry → SRVC_ACK and FWRST pulse one cycle later, STATE back to CLOSED, FAULT_CNT stays 0.
- Early service: CWLEN=10, WDSRVC at cycle 3 of CLOSED → EARLY_ERR pulse, FAULT_CNT=1, CLOSED counter restarts, OPEN reached 10 cycles later.
- Late fault and collision: in OPEN, raise FWOVR and WDSRVC in the same cycle → LATE_ERR only, no SRVC_ACK, FAULT_CNT=1, FWRST pulse.
- Escalation: FAULT_LIMIT=3, RSTOUT_LEN=8, three early services → third EARLY_ERR followed by SYSRST high exactly 8 cycles, FAULT_CNT=0, STATE ends at IDLE.
- Forgiveness and reset:
  - FAULT_CNT=2, then valid service → FAULT_CNT=1.
  - WDRST asserted on SYSRST cycle 3 → SYSRST=0 and STATE=IDLE next cycle.
  - EN=0 mid-ESCAL → pulse still completes.
- CWLEN=0: EN rise → STATE goes IDLE→OPEN directly; immediate WDSRVC → SRVC_ACK, not EARLY_ERR.
